// File: rtl/hs_weighted_dispatch_if.sv
// hs_weighted_dispatch_if: stream-in / REQ_NUM-lanes-out bundle for the weighted packet dispatcher
// Ports (signals):
//   valid_in, data_in, last_in, ready_in   upstream valid/ready/last stream
//   weights                                 per-lane weight, lane i at [i*WEIGHT_W +: WEIGHT_W]
//   valid_out, data_out, last_out, ready_out per-lane downstream streams
//   cur_dest, dest_ok                       routing status
// master drives the upstream beat, weights and downstream ready; slave is the dispatcher.
interface hs_weighted_dispatch_if #(
    parameter int REQ_NUM  = 8,
    parameter int DATA_W   = 1,
    parameter int WEIGHT_W = 4
);
    logic                          valid_in;
    logic [DATA_W-1:0]             data_in;
    logic                          last_in;
    logic                          ready_in;
    logic [REQ_NUM*WEIGHT_W-1:0]   weights;
    logic [REQ_NUM-1:0]            valid_out;
    logic [REQ_NUM*DATA_W-1:0]     data_out;
    logic [REQ_NUM-1:0]            last_out;
    logic [REQ_NUM-1:0]            ready_out;
    logic [$clog2(REQ_NUM)-1:0]    cur_dest;
    logic                          dest_ok;

    modport master (
        output valid_in, data_in, last_in, weights, ready_out,
        input  ready_in, valid_out, data_out, last_out, cur_dest, dest_ok
    );

    modport slave (
        input  valid_in, data_in, last_in, weights, ready_out,
        output ready_in, valid_out, data_out, last_out, cur_dest, dest_ok
    );
endinterface

// File: rtl/hs_weighted_dispatch.sv
// hs_weighted_dispatch: distributes whole packets of one stream over REQ_NUM lanes in weighted round-robin order
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; forces all outputs to 0 while high
//   bus  slave side of hs_weighted_dispatch_if (upstream stream, weights, lane streams, status)
module hs_weighted_dispatch #(
    parameter int REQ_NUM  = 8,
    parameter int DATA_W   = 1,
    parameter int WEIGHT_W = 4
) (
    input logic                   clk,
    input logic                   rst,
    hs_weighted_dispatch_if.slave bus
);
    localparam int PW = $clog2(REQ_NUM);

    logic [PW-1:0]       ptr;
    logic [PW-1:0]       scan;
    logic [PW-1:0]       lane;
    logic [PW-1:0]       dest;
    logic [WEIGHT_W-1:0] credit;
    logic [WEIGHT_W-1:0] w [REQ_NUM];
    logic                in_pkt;
    logic                any_w;
    logic                keep;
    logic                ok;
    logic                fire;

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_w
        assign w[i] = bus.weights[i*WEIGHT_W +: WEIGHT_W];
    end

    // Scan from farthest to nearest so the nearest enabled lane after ptr wins;
    // k == REQ_NUM lands on ptr itself, making it the last candidate.
    always_comb begin
        scan  = ptr;
        any_w = 1'b0;
        lane  = '0;
        for (int k = REQ_NUM; k >= 1; k--) begin
            lane = PW'((int'(ptr) + k) % REQ_NUM);
            if (w[lane] != '0) begin
                scan  = lane;
                any_w = 1'b1;
            end
        end
    end

    // Stay on ptr while it still has credit left; mid-packet the lane is locked regardless of weights.
    assign keep = (w[ptr] != '0) && (credit < w[ptr]);
    assign dest = (in_pkt || keep) ? ptr : scan;
    assign ok   = !rst && (in_pkt || any_w);
    assign fire = ok && bus.valid_in && bus.ready_out[dest];

    assign bus.dest_ok  = ok;
    assign bus.ready_in = ok && bus.ready_out[dest];
    assign bus.cur_dest = rst ? '0 : dest;

    always_comb begin
        bus.valid_out = '0;
        bus.last_out  = '0;
        bus.data_out  = '0;
        if (ok) begin
            bus.valid_out[dest]                          = bus.valid_in;
            bus.last_out[dest]                           = bus.last_in;
            bus.data_out[int'(dest)*DATA_W +: DATA_W]    = bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            credit <= '0;
            in_pkt <= 1'b0;
        end else if (fire) begin
            if (!in_pkt) begin
                ptr    <= dest;
                credit <= keep ? credit + 1'b1 : WEIGHT_W'(1);
            end
            in_pkt <= !bus.last_in;
        end
    end
endmodule
